// File: rtl/ft_wb_checker.sv
// ft_wb_checker
// -------------
// Write-back checker and recovery controller for NCORES redundant cores
// (2 = dual lockstep, detect only; 3 = triple modular, majority vote).
// Each core's register-file write stream is buffered in its own FIFO, so the
// cores may drift apart by up to DEPTH writes. When every FIFO holds at least
// one entry, all heads are compared and popped together. A major
// (unmaskable) error flushes the FIFOs and starts the recovery sequence:
// HALT raises a debug request until the cores report done, then RESET holds
// the core reset for RST_CYCLES cycles before checking resumes.
//
// Optional feature: define FT_SKEW_WATCHDOG_EN to add a skew watchdog that
// raises a major error after MAX_SKEW cycles in which some FIFOs hold
// entries while others are empty.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   enable_i       checking enable (0 blocks pushes and errors)
//   we_i           per-core write enable            [NCORES]
//   waddr_i        per-core write address, packed   [NCORES*ADDR_W]
//   wdata_i        per-core write data, packed      [NCORES*DATA_W]
//   pc_i           core 0 PC, stored with core 0 entries
//   force_error_i  injects a major error
//   done_i         recovery routine finished (sampled in HALT only)
//   error_o        one-cycle pulse per detected error
//   major_o        error_o qualifier: error was unmaskable
//   faulty_o       sticky per-core fault flags      [NCORES]
//   err_count_o    saturating error count
//   err_pc_o       core 0 PC involved in the last error
//   recover_o      debug request to all cores (HALT)
//   reset_o        core reset request (RESET)
//   recovering_o   high in any state except RUN
module ft_wb_checker #(
    parameter int NCORES     = 2,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 4,
    parameter int RST_CYCLES = 4,
    parameter int MAX_SKEW   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic [NCORES-1:0]        we_i,
    input  logic [NCORES*ADDR_W-1:0] waddr_i,
    input  logic [NCORES*DATA_W-1:0] wdata_i,
    input  logic [31:0]              pc_i,
    input  logic                     force_error_i,
    input  logic                     done_i,
    output logic                     error_o,
    output logic                     major_o,
    output logic [NCORES-1:0]        faulty_o,
    output logic [7:0]               err_count_o,
    output logic [31:0]              err_pc_o,
    output logic                     recover_o,
    output logic                     reset_o,
    output logic                     recovering_o
);

    localparam int ENT_W = ADDR_W + DATA_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int RC_W  = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Parameter legality checks at elaboration time.
    if ((NCORES != 2) && (NCORES != 3)) begin : g_bad_ncores
        $error("ft_wb_checker: NCORES must be 2 or 3");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("ft_wb_checker: DEPTH must be a power of two >= 2");
    end
    if ((RST_CYCLES < 1) || (MAX_SKEW < 1)) begin : g_bad_cycles
        $error("ft_wb_checker: RST_CYCLES and MAX_SKEW must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_RESET = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [RC_W-1:0]   rst_cnt_reg, rst_cnt_next;

    logic              run_en;
    logic              compare;
    logic              flush;
    logic [NCORES-1:0] push, full, empty, ovf;
    logic [ENT_W-1:0]  head [NCORES];
    logic [31:0]       head_pc;

    logic              cmp_major, cmp_minor;
    logic [NCORES-1:0] cmp_faulty;
    logic              force_err, wd_fire;
    logic              any_major, any_err;

    logic              error_reg, major_reg;
    logic [NCORES-1:0] faulty_reg;
    logic [7:0]        err_count_reg;
    logic [31:0]       err_pc_reg;

    // Pushes, compares and injected errors only happen while checking.
    assign run_en  = (state_reg == ST_RUN) && enable_i;
    assign compare = run_en && (empty == '0);

    // ------------------------------------------------------------------
    // Per-core FIFOs. Heads are read combinationally so the compare can
    // act in the cycle after the write.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NCORES; gi++) begin : g_fifo
        logic [ENT_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
        logic [CNT_W-1:0] count_reg;
        logic             wr_en;

        assign push[gi]  = run_en & we_i[gi];
        assign empty[gi] = (count_reg == '0);
        assign full[gi]  = (count_reg == FULL_CNT);
        // A full FIFO that pops in the same cycle still has room.
        assign ovf[gi]   = push[gi] & full[gi] & ~compare;
        assign wr_en     = push[gi] & (~full[gi] | compare);
        assign head[gi]  = mem[rd_ptr_reg];

        always_ff @(posedge clk_i) begin
            if (wr_en) begin
                mem[wr_ptr_reg] <= {waddr_i[gi*ADDR_W +: ADDR_W],
                                    wdata_i[gi*DATA_W +: DATA_W]};
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                end
                if (compare) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
                if (wr_en && !compare) begin
                    count_reg <= count_reg + CNT_W'(1);
                end else if (!wr_en && compare) begin
                    count_reg <= count_reg - CNT_W'(1);
                end
            end
        end

        // Core 0 entries also carry the PC that retired the write.
        if (gi == 0) begin : g_pc
            logic [31:0] pc_mem [DEPTH];

            always_ff @(posedge clk_i) begin
                if (wr_en) begin
                    pc_mem[wr_ptr_reg] <= pc_i;
                end
            end

            assign head_pc = pc_mem[rd_ptr_reg];
        end
    end

    // ------------------------------------------------------------------
    // Head comparison
    // ------------------------------------------------------------------
    if (NCORES == 2) begin : g_dmr
        // Lockstep pair: any difference is unmaskable, both cores suspect.
        assign cmp_major  = compare & (head[0] != head[1]);
        assign cmp_minor  = 1'b0;
        assign cmp_faulty = '1;
    end else begin : g_tmr
        logic e01, e02, e12;

        assign e01 = (head[0] == head[1]);
        assign e02 = (head[0] == head[2]);
        assign e12 = (head[1] == head[2]);

        // Two agreeing cores outvote the third; three-way disagreement
        // cannot be resolved.
        always_comb begin
            cmp_major  = 1'b0;
            cmp_minor  = 1'b0;
            cmp_faulty = '0;
            if (compare && !(e01 && e02)) begin
                if (e12) begin
                    cmp_minor     = 1'b1;
                    cmp_faulty[0] = 1'b1;
                end else if (e02) begin
                    cmp_minor     = 1'b1;
                    cmp_faulty[1] = 1'b1;
                end else if (e01) begin
                    cmp_minor     = 1'b1;
                    cmp_faulty[2] = 1'b1;
                end else begin
                    cmp_major     = 1'b1;
                    cmp_faulty    = '1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional skew watchdog
    // ------------------------------------------------------------------
`ifdef FT_SKEW_WATCHDOG_EN
    localparam int WD_W = $clog2(MAX_SKEW + 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            skew;

    assign skew    = run_en && (empty != '0) && (empty != '1);
    assign wd_fire = skew && (wd_cnt_reg == WD_W'(MAX_SKEW - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_reg <= '0;
        end else if ((state_reg != ST_RUN) || flush || compare ||
                     (empty == '1) || wd_fire) begin
            wd_cnt_reg <= '0;
        end else if (skew) begin
            wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Error merge and status registers
    // ------------------------------------------------------------------
    assign force_err = run_en & force_error_i;
    assign any_major = cmp_major | (|ovf) | force_err | wd_fire;
    assign any_err   = any_major | cmp_minor;
    assign flush     = any_major;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            error_reg     <= 1'b0;
            major_reg     <= 1'b0;
            faulty_reg    <= '0;
            err_count_reg <= '0;
            err_pc_reg    <= '0;
        end else begin
            error_reg <= any_err;
            major_reg <= any_major;
            if (cmp_major || cmp_minor) begin
                faulty_reg <= faulty_reg | cmp_faulty;
            end
            if (any_err) begin
                if (err_count_reg != 8'hFF) begin
                    err_count_reg <= err_count_reg + 8'd1;
                end
                // With no buffered core 0 entry, the write being pushed is
                // the best PC reference available.
                err_pc_reg <= empty[0] ? pc_i : head_pc;
            end
        end
    end

    assign error_o     = error_reg;
    assign major_o     = major_reg;
    assign faulty_o    = faulty_reg;
    assign err_count_o = err_count_reg;
    assign err_pc_o    = err_pc_reg;

    // ------------------------------------------------------------------
    // Recovery state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= ST_RUN;
            rst_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rst_cnt_reg <= rst_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rst_cnt_next = rst_cnt_reg;
        recover_o    = 1'b0;
        reset_o      = 1'b0;
        recovering_o = 1'b1;
        case (state_reg)
            ST_RUN: begin
                recovering_o = 1'b0;
                if (any_major) begin
                    state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                recover_o = 1'b1;
                if (done_i) begin
                    state_next   = ST_RESET;
                    rst_cnt_next = '0;
                end
            end
            ST_RESET: begin
                reset_o = 1'b1;
                if (rst_cnt_reg == RC_W'(RST_CYCLES - 1)) begin
                    state_next = ST_RUN;
                end else begin
                    rst_cnt_next = rst_cnt_reg + RC_W'(1);
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_ft_wb_checker.sv
module tb_ft_wb_checker;

    typedef struct packed {
        logic        major;
        logic [2:0]  faulty;
        logic [7:0]  cnt;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    exp_t q2[$];
    exp_t q3[$];

    // DMR instance signals
    logic        en2, force2, done2;
    logic [1:0]  we2;
    logic [9:0]  waddr2;
    logic [63:0] wdata2;
    logic [31:0] pc2;
    logic        err2, maj2, rec2, rsto2, ring2;
    logic [1:0]  faulty2;
    logic [7:0]  cnt2;
    logic [31:0] epc2;

    // TMR instance signals
    logic        en3, force3, done3;
    logic [2:0]  we3;
    logic [14:0] waddr3;
    logic [95:0] wdata3;
    logic [31:0] pc3;
    logic        err3, maj3, rec3, rsto3, ring3;
    logic [2:0]  faulty3;
    logic [7:0]  cnt3;
    logic [31:0] epc3;

    ft_wb_checker #(.NCORES(2)) d2 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en2), .we_i(we2),
        .waddr_i(waddr2), .wdata_i(wdata2), .pc_i(pc2),
        .force_error_i(force2), .done_i(done2),
        .error_o(err2), .major_o(maj2), .faulty_o(faulty2),
        .err_count_o(cnt2), .err_pc_o(epc2), .recover_o(rec2),
        .reset_o(rsto2), .recovering_o(ring2)
    );

    ft_wb_checker #(.NCORES(3)) d3 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en3), .we_i(we3),
        .waddr_i(waddr3), .wdata_i(wdata3), .pc_i(pc3),
        .force_error_i(force3), .done_i(done3),
        .error_o(err3), .major_o(maj3), .faulty_o(faulty3),
        .err_count_o(cnt3), .err_pc_o(epc3), .recover_o(rec3),
        .reset_o(rsto3), .recovering_o(ring3)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic set2(input logic [1:0] we, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [31:0] pc);
        we2    = we;
        waddr2 = {5'd5, 5'd5};
        wdata2 = {d1, d0};
        pc2    = pc;
    endtask

    task automatic set3(input logic [2:0] we, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] pc);
        we3    = we;
        waddr3 = {5'd5, 5'd5, 5'd5};
        wdata3 = {d2, d1, d0};
        pc3    = pc;
    endtask

    // HALT hold, done handshake, RESET_CYCLES-long core reset, back to RUN.
    task automatic recover2();
        repeat (3) begin
            @(negedge clk);
            chk("d2_halt_hold", {62'd0, rec2, rsto2}, 64'b10);
        end
        done2 = 1'b1;
        @(negedge clk);
        done2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("d2_reset_cycle", {61'd0, rec2, rsto2, ring2}, 64'b011);
            @(negedge clk);
        end
        chk("d2_recovery_end", {62'd0, rsto2, ring2}, 64'd0);
    endtask

    task automatic recover3();
        repeat (3) begin
            @(negedge clk);
            chk("d3_halt_hold", {62'd0, rec3, rsto3}, 64'b10);
        end
        done3 = 1'b1;
        @(negedge clk);
        done3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("d3_reset_cycle", {61'd0, rec3, rsto3, ring3}, 64'b011);
            @(negedge clk);
        end
        chk("d3_recovery_end", {62'd0, rsto3, ring3}, 64'd0);
    endtask

    // Scoreboard monitors: every error pulse is matched against the queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && err2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_total++;
                $display("FAIL sb_d2_unexpected: got error pc=0x%0h expected no error", epc2);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("sb_d2_error", {20'd0, maj2, 1'b0, faulty2, cnt2, epc2}, {20'd0, e});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && err3 === 1'b1) begin
            if (q3.size() == 0) begin
                n_total++;
                $display("FAIL sb_d3_unexpected: got error pc=0x%0h expected no error", epc3);
            end else begin
                exp_t e;
                e = q3.pop_front();
                chk("sb_d3_error", {20'd0, maj3, faulty3, cnt3, epc3}, {20'd0, e});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en2 = 1'b1; force2 = 1'b0; done2 = 1'b0;
        en3 = 1'b1; force3 = 1'b0; done3 = 1'b0;
        set2(2'b00, 0, 0, 0);
        set3(3'b000, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("d2_reset_state", {17'd0, err2, maj2, faulty2, cnt2, epc2, rec2, rsto2, ring2}, 64'd0);
        chk("d3_reset_state", {16'd0, err3, maj3, faulty3, cnt3, epc3, rec3, rsto3, ring3}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- DMR ----------------
        set2(2'b11, 32'h1234, 32'h1234, 32'h10);
        @(negedge clk); set2(2'b00, 0, 0, 0);
        chk("d2_aligned_t1", {63'd0, err2}, 64'd0);
        @(negedge clk);
        chk("d2_aligned_t2", {62'd0, err2, ring2}, 64'd0);
        repeat (2) @(negedge clk);

        en2 = 1'b0;
        set2(2'b11, 32'h1234, 32'h9999, 32'h20);
        @(negedge clk); set2(2'b00, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("d2_enable_off", {55'd0, err2, cnt2}, 64'd0);
        en2 = 1'b1;

        q2.push_back('{1'b1, 3'b011, 8'd1, 32'h80});
        set2(2'b11, 32'h1234, 32'h1235, 32'h80);
        @(negedge clk); set2(2'b00, 0, 0, 0);
        chk("d2_mismatch_t1", {63'd0, err2}, 64'd0);
        @(negedge clk);
        chk("d2_mismatch_t2", {60'd0, err2, maj2, rec2, ring2}, 64'b1111);
        recover2();

        // Five pushes into core 0 only: the fifth overflows.
        q2.push_back('{1'b1, 3'b011, 8'd2, 32'h100});
        for (int i = 0; i < 5; i++) begin
            set2(2'b01, 32'h500 + i, 0, 32'h100 + i);
            @(negedge clk);
            if (i < 4) chk("d2_ovf_pre", {63'd0, err2}, 64'd0);
        end
        set2(2'b00, 0, 0, 0);
        chk("d2_ovf_err", {61'd0, err2, maj2, rec2}, 64'b111);
        recover2();

        // Stale entries would mismatch here if the flush had not happened.
        set2(2'b11, 32'h77, 32'h77, 32'h30);
        @(negedge clk); set2(2'b00, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("d2_post_flush", {55'd0, err2, cnt2}, {55'd0, 1'b0, 8'd2});

        // Asynchronous reset in the middle of RESET.
        q2.push_back('{1'b1, 3'b011, 8'd3, 32'h200});
        set2(2'b11, 32'h1, 32'h2, 32'h200);
        @(negedge clk); set2(2'b00, 0, 0, 0);
        @(negedge clk);
        chk("d2_mm2_err", {63'd0, err2}, 64'd1);
        @(negedge clk);
        done2 = 1'b1;
        @(negedge clk); done2 = 1'b0;
        @(negedge clk);
        chk("d2_in_reset", {63'd0, rsto2}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("d2_async_rst", {17'd0, err2, maj2, faulty2, cnt2, epc2, rec2, rsto2, ring2}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set2(2'b11, 32'habc, 32'habc, 32'h40);
        @(negedge clk); set2(2'b00, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("d2_post_rst_aligned", {55'd0, err2, cnt2}, 64'd0);
        q2.push_back('{1'b1, 3'b011, 8'd1, 32'h300});
        set2(2'b11, 32'h5, 32'h6, 32'h300);
        @(negedge clk); set2(2'b00, 0, 0, 0);
        @(negedge clk);
        chk("d2_post_rst_mm", {62'd0, err2, maj2}, 64'b11);
        recover2();

`ifdef FT_SKEW_WATCHDOG_EN
        q2.push_back('{1'b1, 3'b011, 8'd2, 32'h400});
        set2(2'b01, 32'h9, 0, 32'h400);
        @(negedge clk); set2(2'b00, 0, 0, 0);
        chk("d2_wd_quiet", {63'd0, err2}, 64'd0);
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            chk("d2_wd_quiet", {63'd0, err2}, 64'd0);
        end
        @(negedge clk);
        chk("d2_wd_fire", {62'd0, err2, maj2}, 64'b11);
        recover2();
`else
        set2(2'b01, 32'h9, 0, 32'h400);
        @(negedge clk); set2(2'b00, 0, 0, 0);
        repeat (20) @(negedge clk);
        chk("d2_no_watchdog", {55'd0, err2, cnt2}, {55'd0, 1'b0, 8'd1});
`endif

        // ---------------- TMR ----------------
        set3(3'b111, 32'h42, 32'h42, 32'h42, 32'h38);
        @(negedge clk); set3(3'b000, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("d3_aligned", {55'd0, err3, cnt3}, 64'd0);

        q3.push_back('{1'b0, 3'b100, 8'd1, 32'h40});
        set3(3'b111, 32'h1234, 32'h1234, 32'h1334, 32'h40);
        @(negedge clk); set3(3'b000, 0, 0, 0, 0);
        @(negedge clk);
        chk("d3_minor2_t2", {60'd0, err3, maj3, rec3, ring3}, 64'b1000);
        repeat (3) begin
            @(negedge clk);
            chk("d3_minor_no_recover", {62'd0, rec3, ring3}, 64'd0);
        end

        q3.push_back('{1'b0, 3'b101, 8'd2, 32'h41});
        set3(3'b111, 32'h9, 32'h8, 32'h8, 32'h41);
        @(negedge clk); set3(3'b000, 0, 0, 0, 0);
        @(negedge clk);
        chk("d3_minor0_t2", {62'd0, err3, maj3}, 64'b10);

        // Cores drift by one write each: buffering absorbs it.
        set3(3'b001, 32'h7, 0, 0, 32'h50);
        @(negedge clk); set3(3'b010, 0, 32'h7, 0, 0);
        @(negedge clk); set3(3'b100, 0, 0, 32'h7, 0);
        @(negedge clk); set3(3'b000, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("d3_skewed_ok", {55'd0, err3, cnt3}, {55'd0, 1'b0, 8'd2});

        q3.push_back('{1'b1, 3'b111, 8'd3, 32'h60});
        set3(3'b111, 32'h1, 32'h2, 32'h3, 32'h60);
        @(negedge clk); set3(3'b000, 0, 0, 0, 0);
        @(negedge clk);
        chk("d3_all_differ", {61'd0, err3, maj3, rec3}, 64'b111);
        recover3();

        q3.push_back('{1'b1, 3'b111, 8'd4, 32'h99});
        force3 = 1'b1; pc3 = 32'h99;
        @(negedge clk);
        force3 = 1'b0; pc3 = 32'h0;
        chk("d3_force", {61'd0, err3, maj3, rec3}, 64'b111);
        recover3();

        chk("q2_drained", 64'(q2.size()), 64'd0);
        chk("q3_drained", 64'(q3.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
